// File: rtl/tl_ul_source_arbiter.sv
// Round-robin TL-UL A/D arbiter: NREQ requesters share one channel pair toward the fragmenter.
// Each A message is locked to one grant, and each D response is routed back by the index prefix on its source.
module tl_ul_source_arbiter #(
  parameter int NREQ      = 4,
  parameter int SRC_W     = 3,
  parameter int MAX_OUTST = 4,
  localparam int PW       = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_a_valid,
  output logic [NREQ-1:0]         req_a_ready,
  input  logic [3*NREQ-1:0]       req_a_opcode,
  input  logic [3*NREQ-1:0]       req_a_param,
  input  logic [3*NREQ-1:0]       req_a_size,
  input  logic [SRC_W*NREQ-1:0]   req_a_source,
  input  logic [26*NREQ-1:0]      req_a_address,
  input  logic [4*NREQ-1:0]       req_a_mask,
  input  logic [32*NREQ-1:0]      req_a_data,
  input  logic [NREQ-1:0]         req_a_corrupt,
  output logic [NREQ-1:0]         req_d_valid,
  input  logic [NREQ-1:0]         req_d_ready,
  output logic [2:0]              req_d_opcode,
  output logic [2:0]              req_d_size,
  output logic [SRC_W-1:0]        req_d_source,
  output logic [31:0]             req_d_data,
  output logic                    out_a_valid,
  input  logic                    out_a_ready,
  output logic [2:0]              out_a_opcode,
  output logic [2:0]              out_a_param,
  output logic [2:0]              out_a_size,
  output logic [SRC_W+PW-1:0]     out_a_source,
  output logic [25:0]             out_a_address,
  output logic [3:0]              out_a_mask,
  output logic [31:0]             out_a_data,
  output logic                    out_a_corrupt,
  input  logic                    out_d_valid,
  output logic                    out_d_ready,
  input  logic [2:0]              out_d_opcode,
  input  logic [2:0]              out_d_size,
  input  logic [SRC_W+PW-1:0]     out_d_source,
  input  logic [31:0]             out_d_data,
  output logic                    busy,
  output logic                    dbg_state
);

  // Handshake: a beat transfers on a rising edge where valid && ready; valid never depends on ready
  // and, once raised, holds with stable payload until that transfer.
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

  state_e          state;
  logic [PW-1:0]   rr_ptr, lock_idx, grant, d_idx;
  logic [5:0]      a_beats_left, d_beats_left, a_beats, d_beats;
  logic [3:0]      outst [NREQ];
  logic [NREQ-1:0] eligible, outst_inc, outst_dec, outst_nz;
  logic            grant_vld, a_fire, a_first, a_last;
  logic            d_hit, d_route, d_fire, d_last;

  logic [2:0]       a_opcode [NREQ];
  logic [2:0]       a_param  [NREQ];
  logic [2:0]       a_size   [NREQ];
  logic [SRC_W-1:0] a_source [NREQ];
  logic [25:0]      a_address[NREQ];
  logic [3:0]       a_mask   [NREQ];
  logic [31:0]      a_data   [NREQ];

  function automatic logic [5:0] msg_beats(input logic multi, input logic [2:0] size);
    msg_beats = (multi && size > 3'd2) ? (6'd1 << (size - 3'd2)) : 6'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_opcode[i]  = req_a_opcode[3*i +: 3];
      a_param[i]   = req_a_param[3*i +: 3];
      a_size[i]    = req_a_size[3*i +: 3];
      a_source[i]  = req_a_source[SRC_W*i +: SRC_W];
      a_address[i] = req_a_address[26*i +: 26];
      a_mask[i]    = req_a_mask[4*i +: 4];
      a_data[i]    = req_a_data[32*i +: 32];
      eligible[i]  = req_a_valid[i] && (outst[i] < MAX_O);
      outst_nz[i]  = (outst[i] != 4'd0);
    end
  end

  // Lowest rotation offset from rr_ptr wins; the loop runs downward so that offset is written last.
  always_comb begin
    logic [PW:0] slot;
    slot      = '0;
    grant     = lock_idx;
    grant_vld = 1'b0;
    if (state == BURST) begin
      grant_vld = req_a_valid[lock_idx];
    end else begin
      grant = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
        slot = {1'b0, rr_ptr} + (PW+1)'(k);
        if (slot >= (PW+1)'(NREQ)) slot = slot - (PW+1)'(NREQ);
        if (eligible[slot[PW-1:0]]) begin
          grant     = slot[PW-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign out_a_valid   = reset_n && grant_vld;
  assign out_a_opcode  = a_opcode[grant];
  assign out_a_param   = a_param[grant];
  assign out_a_size    = a_size[grant];
  assign out_a_source  = {grant, a_source[grant]};
  assign out_a_address = a_address[grant];
  assign out_a_mask    = a_mask[grant];
  assign out_a_data    = a_data[grant];
  assign out_a_corrupt = req_a_corrupt[grant];

  assign a_fire  = out_a_valid && out_a_ready;
  assign a_first = (state == IDLE);
  assign a_beats = msg_beats(a_opcode[grant][2:1] == 2'b00, a_size[grant]);
  assign a_last  = a_first ? (a_beats == 6'd1) : (a_beats_left == 6'd1);

  always_comb begin
    req_a_ready        = '0;
    req_a_ready[grant] = a_fire;
  end

  // D beats for a requester with nothing outstanding are swallowed rather than delivered.
  assign d_idx   = out_d_source[SRC_W +: PW];
  assign d_hit   = (int'(d_idx) < NREQ);
  assign d_route = d_hit && outst_nz[d_idx];
  assign d_beats = msg_beats(out_d_opcode == 3'd1, out_d_size);
  assign d_last  = (d_beats_left == 6'd0) ? (d_beats == 6'd1) : (d_beats_left == 6'd1);

  always_comb begin
    req_d_valid = '0;
    if (reset_n && d_route) req_d_valid[d_idx] = out_d_valid;
  end

  assign out_d_ready  = reset_n && (d_route ? req_d_ready[d_idx] : 1'b1);
  assign d_fire       = out_d_valid && out_d_ready;
  assign req_d_opcode = out_d_opcode;
  assign req_d_size   = out_d_size;
  assign req_d_source = out_d_source[SRC_W-1:0];
  assign req_d_data   = out_d_data;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      outst_inc[i] = a_fire && a_first && (grant == PW'(i));
      outst_dec[i] = d_fire && d_last && d_route && (d_idx == PW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      lock_idx     <= '0;
      a_beats_left <= '0;
      rr_ptr       <= '0;
      d_beats_left <= '0;
    end else begin
      if (a_fire) begin
        if (a_first && !a_last) begin
          state        <= BURST;
          lock_idx     <= grant;
          a_beats_left <= a_beats - 6'd1;
        end else if (!a_first) begin
          a_beats_left <= a_beats_left - 6'd1;
          if (a_last) state <= IDLE;
        end
        if (a_last) rr_ptr <= (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      if (d_fire) d_beats_left <= (d_beats_left == 6'd0) ? d_beats - 6'd1 : d_beats_left - 6'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) outst[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (outst_inc[i] && !outst_dec[i]) outst[i] <= outst[i] + 4'd1;
        else if (outst_dec[i] && !outst_inc[i]) outst[i] <= outst[i] - 4'd1;
      end
    end
  end

  assign busy      = reset_n && ((state == BURST) || (|outst_nz));
  assign dbg_state = state;

  a_no_d_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    (out_d_valid && d_hit) |-> outst_nz[d_idx]);

endmodule

// File: tb/tb_tl_ul_source_arbiter.sv
// Directed bench for tl_ul_source_arbiter: a per-cycle vector table for round-robin A arbitration,
// followed by hand-written sequences for bursts, outstanding limits, D routing and reset.
module tb_tl_ul_source_arbiter;
  localparam int NREQ = 4, SRC_W = 3, MAX_OUTST = 4, PW = 2, OSW = SRC_W + PW;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req_a_valid, req_a_ready, req_a_corrupt, req_d_valid, req_d_ready;
  logic [3*NREQ-1:0]     req_a_opcode, req_a_param, req_a_size;
  logic [SRC_W*NREQ-1:0] req_a_source;
  logic [26*NREQ-1:0]    req_a_address;
  logic [4*NREQ-1:0]     req_a_mask;
  logic [32*NREQ-1:0]    req_a_data;
  logic [2:0]            req_d_opcode, req_d_size, out_a_opcode, out_a_param, out_a_size;
  logic [SRC_W-1:0]      req_d_source;
  logic [31:0]           req_d_data, out_a_data, out_d_data;
  logic                  out_a_valid, out_a_ready, out_a_corrupt, out_d_valid, out_d_ready;
  logic [OSW-1:0]        out_a_source, out_d_source;
  logic [25:0]           out_a_address;
  logic [3:0]            out_a_mask;
  logic [2:0]            out_d_opcode, out_d_size;
  logic                  busy, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OSW+31:0] exp_q[$];
  logic            sb_on = 1'b0;

  typedef struct {
    logic [3:0] valid;
    logic       a_ready;
    logic       exp_valid;
    logic [4:0] exp_src;
    logic [3:0] exp_rdy;
  } vec_t;
  vec_t vecs[10];

  tl_ul_source_arbiter #(.NREQ(NREQ), .SRC_W(SRC_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_opcode(req_a_opcode),
    .req_a_param(req_a_param), .req_a_size(req_a_size), .req_a_source(req_a_source),
    .req_a_address(req_a_address), .req_a_mask(req_a_mask), .req_a_data(req_a_data),
    .req_a_corrupt(req_a_corrupt),
    .req_d_valid(req_d_valid), .req_d_ready(req_d_ready), .req_d_opcode(req_d_opcode),
    .req_d_size(req_d_size), .req_d_source(req_d_source), .req_d_data(req_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected summary before 50000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge, checks run on the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic set_port(input int i, input logic [2:0] op, input logic [2:0] sz, input logic [31:0] dat);
    req_a_opcode[3*i +: 3] = op;
    req_a_size[3*i +: 3]   = sz;
    req_a_data[32*i +: 32] = dat;
  endtask

  task automatic clear_inputs();
    req_a_valid = '0;
    out_a_ready = 1'b0;
    out_d_valid = 1'b0;
    req_d_ready = '0;
    out_d_opcode = 3'd0;
    out_d_size = 3'd2;
    out_d_source = '0;
    out_d_data = 32'hD0D0_0000;
    req_a_corrupt = '0;
    req_a_param = '0;
    for (int i = 0; i < NREQ; i++) begin
      set_port(i, 3'd4, 3'd2, 32'hA000_0000 + 32'(i));
      req_a_source[SRC_W*i +: SRC_W] = 3'(i + 4);
      req_a_address[26*i +: 26] = 26'(i * 16);
      req_a_mask[4*i +: 4] = 4'hF;
    end
  endtask

  task automatic set_d(input logic [2:0] op, input logic [2:0] sz, input logic [OSW-1:0] src,
                       input logic [3:0] rdy);
    out_d_valid  = 1'b1;
    out_d_opcode = op;
    out_d_size   = sz;
    out_d_source = src;
    req_d_ready  = rdy;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Scoreboard: every A beat accepted while enabled must match the head of exp_q.
  always @(negedge clock) begin
    if (sb_on && reset_n && out_a_valid && out_a_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got beat %0h expected none", {out_a_source, out_a_data});
      end else begin
        check("sb_beat", {out_a_source, out_a_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0] = '{4'b1111, 1'b1, 1'b1, 5'd4,  4'b0001};
    vecs[1] = '{4'b1111, 1'b1, 1'b1, 5'd13, 4'b0010};
    vecs[2] = '{4'b1111, 1'b1, 1'b1, 5'd22, 4'b0100};
    vecs[3] = '{4'b1111, 1'b1, 1'b1, 5'd31, 4'b1000};
    vecs[4] = '{4'b1111, 1'b1, 1'b1, 5'd4,  4'b0001};
    vecs[5] = '{4'b0101, 1'b1, 1'b1, 5'd22, 4'b0100};
    vecs[6] = '{4'b0001, 1'b0, 1'b1, 5'd4,  4'b0000};
    vecs[7] = '{4'b0000, 1'b1, 1'b0, 5'd0,  4'b0000};
    vecs[8] = '{4'b1000, 1'b1, 1'b1, 5'd31, 4'b1000};
    vecs[9] = '{4'b1110, 1'b1, 1'b1, 5'd13, 4'b0010};

    // Reset gating: everything asks to move while reset_n is low.
    clear_inputs();
    req_a_valid = 4'b1111;
    out_a_ready = 1'b1;
    set_d(3'd1, 3'd2, 5'd0, 4'b1111);
    settle();
    check("rst out_a_valid", out_a_valid, 1'b0);
    check("rst req_a_ready", req_a_ready, 4'b0000);
    check("rst req_d_valid", req_d_valid, 4'b0000);
    check("rst out_d_ready", out_d_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst state", dbg_state, 1'b0);

    // Round-robin table
    do_reset();
    for (int v = 0; v < 10; v++) begin
      req_a_valid = vecs[v].valid;
      out_a_ready = vecs[v].a_ready;
      settle();
      check($sformatf("vec%0d out_a_valid", v), out_a_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check($sformatf("vec%0d out_a_source", v), out_a_source, vecs[v].exp_src);
      check($sformatf("vec%0d req_a_ready", v), req_a_ready, vecs[v].exp_rdy);
      tick();
    end

    // Two-beat PutFull on port 1 holds the grant; port 2 follows on the next cycle.
    do_reset();
    set_port(1, 3'd0, 3'd3, 32'h1111_0001);
    set_port(2, 3'd4, 3'd2, 32'h2222_0002);
    exp_q.push_back({5'd13, 32'h1111_0001});
    exp_q.push_back({5'd13, 32'h1111_0002});
    exp_q.push_back({5'd22, 32'h2222_0002});
    sb_on = 1'b1;
    req_a_valid = 4'b0110;
    out_a_ready = 1'b1;
    settle();
    check("put beat0 ready", req_a_ready, 4'b0010);
    check("put beat0 state", dbg_state, 1'b0);
    tick();
    set_port(1, 3'd0, 3'd3, 32'h1111_0002);
    settle();
    check("put beat1 ready", req_a_ready, 4'b0010);
    check("put beat1 state", dbg_state, 1'b1);
    tick();
    req_a_valid = 4'b0100;
    settle();
    check("after put ready", req_a_ready, 4'b0100);
    check("after put state", dbg_state, 1'b0);
    tick();
    sb_on = 1'b0;
    check("sb drained", exp_q.size(), 0);

    // Outstanding limit on port 0, freed by a single-beat AccessAckData.
    do_reset();
    req_a_valid = 4'b0001;
    out_a_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      settle();
      check($sformatf("outst get%0d ready", n), req_a_ready, 4'b0001);
      tick();
    end
    settle();
    check("outst full valid", out_a_valid, 1'b0);
    check("outst full ready", req_a_ready, 4'b0000);
    check("outst full busy", busy, 1'b1);
    tick();
    set_d(3'd1, 3'd2, 5'd3, 4'b0001);
    out_d_data = 32'hD0D0_0003;
    settle();
    check("outst d cycle a_valid", out_a_valid, 1'b0);
    check("outst d req_d_valid", req_d_valid, 4'b0001);
    check("outst d out_d_ready", out_d_ready, 1'b1);
    check("outst d source", req_d_source, 3'd3);
    check("outst d data", req_d_data, 32'hD0D0_0003);
    tick();
    out_d_valid = 1'b0;
    settle();
    check("outst 5th valid", out_a_valid, 1'b1);
    check("outst 5th ready", req_a_ready, 4'b0001);
    tick();

    // D backpressure to port 2, then a two-beat AccessAckData.
    do_reset();
    req_a_valid = 4'b0100;
    out_a_ready = 1'b1;
    settle();
    check("d2 get ready", req_a_ready, 4'b0100);
    tick();
    req_a_valid = 4'b0000;
    set_d(3'd1, 3'd2, 5'b10101, 4'b0000);
    settle();
    check("d2 stall out_d_ready", out_d_ready, 1'b0);
    check("d2 stall req_d_valid", req_d_valid, 4'b0100);
    check("d2 stall source", req_d_source, 3'd5);
    tick();
    req_d_ready = 4'b0100;
    settle();
    check("d2 release out_d_ready", out_d_ready, 1'b1);
    check("d2 release busy", busy, 1'b1);
    tick();
    out_d_valid = 1'b0;
    settle();
    check("d2 done busy", busy, 1'b0);
    tick();
    req_a_valid = 4'b0100;
    settle();
    tick();
    req_a_valid = 4'b0000;
    set_d(3'd1, 3'd3, 5'b10101, 4'b0100);
    settle();
    tick();
    settle();
    check("d2 beat1 busy", busy, 1'b1);
    check("d2 beat1 req_d_valid", req_d_valid, 4'b0100);
    tick();
    out_d_valid = 1'b0;
    settle();
    check("d2 beat2 busy", busy, 1'b0);
    tick();

    // Port 3: first-beat A fire and last D beat in the same cycle leave the count unchanged.
    do_reset();
    req_a_valid = 4'b1000;
    out_a_ready = 1'b1;
    settle();
    check("p3 first ready", req_a_ready, 4'b1000);
    tick();
    set_d(3'd0, 3'd2, 5'b11001, 4'b1000);
    settle();
    check("p3 both a ready", req_a_ready, 4'b1000);
    check("p3 both d ready", out_d_ready, 1'b1);
    tick();
    out_d_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      settle();
      check($sformatf("p3 fill%0d ready", n), req_a_ready, 4'b1000);
      tick();
    end
    settle();
    check("p3 full ready", req_a_ready, 4'b0000);
    tick();

    // Reset asserted mid-burst with rr_ptr moved away from zero.
    do_reset();
    req_a_valid = 4'b0100;
    out_a_ready = 1'b1;
    settle();
    tick();
    set_port(3, 3'd1, 3'd3, 32'h3333_0001);
    req_a_valid = 4'b1000;
    settle();
    check("mid first ready", req_a_ready, 4'b1000);
    tick();
    req_a_valid = 4'b0111;
    settle();
    check("mid stall valid", out_a_valid, 1'b0);
    check("mid stall ready", req_a_ready, 4'b0000);
    check("mid stall state", dbg_state, 1'b1);
    set_d(3'd1, 3'd2, 5'b10000, 4'b0100);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid rst out_a_valid", out_a_valid, 1'b0);
    check("mid rst req_a_ready", req_a_ready, 4'b0000);
    check("mid rst req_d_valid", req_d_valid, 4'b0000);
    check("mid rst out_d_ready", out_d_ready, 1'b0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst state", dbg_state, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    out_d_valid = 1'b0;
    set_port(3, 3'd4, 3'd2, 32'hA000_0003);
    req_a_valid = 4'b1111;
    settle();
    check("post rst ready", req_a_ready, 4'b0001);
    check("post rst source", out_a_source, 5'd4);
    check("post rst state", dbg_state, 1'b0);
    tick();
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
